// File: rtl/deserializer.sv
`timescale 1ns/1ps
// Receive-side word deserializer: hunts for a sync pattern in the strobed serial stream,
// then packs MSB-first bits into WIDTH-bit words offered downstream over valid/ready.
module deserializer #(
    parameter int unsigned       WIDTH       = 32,
    parameter bit                SYNC_EN     = 1'b1,
    parameter int unsigned       SYNC_W      = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD   = 16'hA5C3,
    parameter int unsigned       FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_en,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] data,
    output logic             Wen,
    output logic             locked,
    output logic             overrun
);

    localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS + 1) : 1;

    localparam logic [0:0] ST_HUNT    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;
    localparam logic [0:0] ST_RESET   = SYNC_EN ? ST_HUNT : ST_COLLECT;

    logic [0:0]        state, state_nx;
    logic [SYNC_W-1:0] sync_sr, sync_nx;
    logic [WIDTH-1:0]  sh, sh_nx;
    logic [BCW-1:0]    bcnt, bcnt_nx;
    logic [WCW-1:0]    wcnt, wcnt_nx;
    logic              pend, pend_nx;
    logic [WIDTH-1:0]  word, word_nx;
    logic [WIDTH-1:0]  data_nx;
    logic              wen_nx, locked_nx, overrun_nx;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RESET;
            sync_sr <= '0;
            sh      <= '0;
            bcnt    <= '0;
            wcnt    <= '0;
            pend    <= 1'b0;
            word    <= '0;
            data    <= '0;
            Wen     <= 1'b0;
            locked  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            sync_sr <= sync_nx;
            sh      <= sh_nx;
            bcnt    <= bcnt_nx;
            wcnt    <= wcnt_nx;
            pend    <= pend_nx;
            word    <= word_nx;
            data    <= data_nx;
            Wen     <= wen_nx;
            locked  <= locked_nx;
            overrun <= overrun_nx;
        end
    end

    // Next-state: output stage for the word completed last cycle, then bit intake
    always_comb begin
        state_nx   = state;
        sync_nx    = sync_sr;
        sh_nx      = sh;
        bcnt_nx    = bcnt;
        wcnt_nx    = wcnt;
        pend_nx    = 1'b0;
        word_nx    = word;
        data_nx    = data;
        wen_nx     = Wen;
        overrun_nx = 1'b0;

        if (pend) begin
            if (!Wen || out_rdy) begin
                data_nx = word;
                wen_nx  = 1'b1;
            end else begin
                overrun_nx = 1'b1;
            end
        end else if (Wen && out_rdy) begin
            wen_nx = 1'b0;
        end

        if (in_en) begin
            if (state == ST_HUNT) begin
                sync_nx = SYNC_W'({sync_sr, in});
                if (sync_nx == SYNC_WORD) begin
                    state_nx = ST_COLLECT;
                    bcnt_nx  = '0;
                    wcnt_nx  = '0;
                end
            end else begin
                sh_nx = WIDTH'({sh, in});
                if (bcnt == BCW'(WIDTH - 1)) begin
                    bcnt_nx = '0;
                    pend_nx = 1'b1;
                    word_nx = sh_nx;
                    wcnt_nx = wcnt + WCW'(1);
                    // Frame complete: drop lock and hunt again from a clean pattern register
                    if (SYNC_EN && (FRAME_WORDS != 0) && (wcnt_nx == WCW'(FRAME_WORDS))) begin
                        state_nx = ST_HUNT;
                        sync_nx  = '0;
                        wcnt_nx  = '0;
                    end
                end else begin
                    bcnt_nx = bcnt + BCW'(1);
                end
            end
        end

        locked_nx = (state_nx == ST_COLLECT);
    end

endmodule

// File: tb/tb_deserializer.sv
`timescale 1ns/1ps
// Bench for deserializer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_deserializer;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned SYNC_W      = 16;
    localparam int unsigned FRAME_WORDS = 4;

    logic             clk;
    logic             rst;
    logic             in;
    logic             in_en;
    logic             out_rdy;
    logic [WIDTH-1:0] data;
    logic             Wen;
    logic             locked;
    logic             overrun;

    int total = 0;
    int bad   = 0;
    int dut_acc = 0;
    bit chk_en = 0;

    logic [15:0] sw = 16'hA5C3;

    deserializer #(
        .WIDTH(WIDTH), .SYNC_EN(1'b1), .SYNC_W(SYNC_W),
        .SYNC_WORD(16'hA5C3), .FRAME_WORDS(FRAME_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .in(in), .in_en(in_en), .out_rdy(out_rdy),
        .data(data), .Wen(Wen), .locked(locked), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: sliding window of the last SYNC_W bits while hunting, a bit queue
    // while locked; a completed word is offered to the output on the following edge.
    logic [31:0] m_data = '0;
    logic [31:0] m_word = '0;
    bit m_wen = 0, m_ovr = 0, m_lock = 0, m_pend = 0;
    int m_wcnt = 0;
    bit hist[$];
    bit bits[$];

    function automatic logic [15:0] hist_val();
        logic [15:0] v = '0;
        foreach (hist[i]) v = {v[14:0], hist[i]};
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_data = '0; m_wen = 0; m_ovr = 0; m_lock = 0; m_pend = 0; m_wcnt = 0;
            hist.delete(); bits.delete();
        end else begin
            m_ovr = 0;
            if (m_pend) begin
                if (!m_wen || out_rdy) begin
                    m_data = m_word;
                    m_wen  = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_wen && out_rdy) begin
                m_wen = 0;
            end
            m_pend = 0;
            if (in_en) begin
                if (!m_lock) begin
                    hist.push_back(in);
                    if (hist.size() > SYNC_W) void'(hist.pop_front());
                    if (hist.size() == SYNC_W && hist_val() == sw) begin
                        m_lock = 1;
                        m_wcnt = 0;
                        bits.delete();
                    end
                end else begin
                    bits.push_back(in);
                    if (bits.size() == WIDTH) begin
                        m_word = '0;
                        foreach (bits[i]) m_word = {m_word[30:0], bits[i]};
                        bits.delete();
                        m_pend = 1;
                        m_wcnt++;
                        if (m_wcnt == FRAME_WORDS) begin
                            m_lock = 0;
                            m_wcnt = 0;
                            hist.delete();
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data", data, m_data);
            chk("Wen", 32'(Wen), 32'(m_wen));
            chk("locked", 32'(locked), 32'(m_lock));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (Wen && out_rdy) dut_acc++;
        end
    end

    task automatic step(input logic b, input logic en, input logic rdy);
        in = b; in_en = en; out_rdy = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input logic rdy, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(v[i], 1'b1, rdy);
            if (gap) step(1'b0, 1'b0, rdy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_data"}, data, 32'h0);
        chk({nm, "_wen"}, 32'(Wen), 32'h0);
        chk({nm, "_locked"}, 32'(locked), 32'h0);
        chk({nm, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    logic [31:0] w1 = 32'h65D96B66;
    logic [31:0] w2 = 32'h001FFFFC;
    logic [31:0] wr;
    int acc_base;

    initial begin
        rst = 1'b1; in = 1'b0; in_en = 1'b0; out_rdy = 1'b0;
        do_reset();
        chk_en = 1;
        chk_zero("reset");

        // Sync then one word
        send_bits(32'(sw), 16, 1'b1, 1'b0);
        chk("t1_locked", 32'(locked), 32'h1);
        send_bits(w1, 32, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t1_wen", 32'(Wen), 32'h1);
        chk("t1_data", data, w1);
        step(1'b0, 1'b0, 1'b1);
        chk("t1_wen_drop", 32'(Wen), 32'h0);

        // False sync pattern never locks
        do_reset();
        send_bits(32'h0000A5C2, 16, 1'b1, 1'b0);
        for (int i = 31; i >= 0; i--) begin
            wr = 32'h12345678;
            step(wr[i], 1'b1, 1'b1);
            chk("t2_locked", 32'(locked), 32'h0);
            chk("t2_wen", 32'(Wen), 32'h0);
        end

        // Back-pressure: second word dropped with an overrun pulse
        do_reset();
        send_bits(32'(sw), 16, 1'b0, 1'b0);
        send_bits(w1, 32, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_data1", data, w1);
        send_bits(w2, 32, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_overrun", 32'(overrun), 32'h1);
        chk("t3_data_held", data, w1);
        step(1'b0, 1'b0, 1'b1);
        chk("t3_wen_drop", 32'(Wen), 32'h0);
        chk("t3_overrun_end", 32'(overrun), 32'h0);

        // Accept on the exact completion cycle of word 2
        do_reset();
        send_bits(32'(sw), 16, 1'b0, 1'b0);
        send_bits(w1, 32, 1'b0, 1'b0);
        send_bits(w2, 32, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t4_data", data, w2);
        chk("t4_wen", 32'(Wen), 32'h1);
        chk("t4_overrun", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b1);

        // Frame end with gapped strobes
        do_reset();
        acc_base = dut_acc;
        send_bits(32'(sw), 16, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) send_bits($urandom, 32, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        chk("t5_locked_fall", 32'(locked), 32'h0);
        chk("t5_words4", 32'(dut_acc - acc_base), 32'd4);
        send_bits(32'h0F0F0F0F, 32, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        chk("t5_fifth_ignored", 32'(dut_acc - acc_base), 32'd4);
        send_bits(32'(sw), 16, 1'b1, 1'b1);
        send_bits($urandom, 32, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1);
        chk("t5_resync_word", 32'(dut_acc - acc_base), 32'd5);

        // Reset mid-word
        do_reset();
        send_bits(32'(sw), 16, 1'b1, 1'b0);
        send_bits($urandom, 10, 1'b1, 1'b0);
        do_reset();
        chk_zero("t6");
        send_bits(32'(sw), 16, 1'b1, 1'b0);
        wr = $urandom;
        send_bits(wr, 32, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t6_data", data, wr);
        chk("t6_wen", 32'(Wen), 32'h1);

        // Randomized soak: injected syncs, random strobes, back-pressure and resets
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(3) != 0) begin
                for (int i = 15; i >= 0; i--) begin
                    while ($urandom_range(3) == 0) step(1'($urandom), 1'b0, 1'($urandom));
                    step(sw[i], 1'b1, 1'($urandom));
                end
            end
            for (int n = $urandom_range(200); n > 0; n--) begin
                step(1'($urandom), 1'($urandom_range(3) != 0), 1'($urandom));
            end
            if ($urandom_range(29) == 0) do_reset();
        end

        step(1'b0, 1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
